// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter
//   Iterative AES key-schedule engine for AES-128/192/256. A single round-word
//   datapath produces one 32-bit schedule word per clock. Every fourth word
//   completes a 128-bit round key, which is presented for one cycle together
//   with its round index.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous reset, active-low
//   start     expansion request, accepted only while ready=1
//   mode      00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_in    cipher key, MSB-aligned (word 0 in the top 32 bits)
//   ready     idle, able to accept start
//   rk_valid  one-cycle strobe qualifying rk_data / rk_idx
//   rk_data   round key, lowest-numbered word in [127:96]
//   rk_idx    round number
//   done      one-cycle pulse with the final rk_valid
//   err       one-cycle pulse when start is given with an unsupported mode
//
// State table
//   state   | meaning
//   IDLE    | ready=1, waiting for start
//   GEN     | one schedule word per cycle, round key every fourth word
//   FIN     | final round key on the outputs; ready follows one cycle later

module aes_key_sched_iter #(
  parameter int MAX_NK   = 8,
  parameter int RK_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  ready,
  output logic                  rk_valid,
  output logic [127:0]          rk_data,
  output logic [RK_IDX_W-1:0]   rk_idx,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = $clog2(MAX_NK);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[w[8*b +: 8]];
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // win_q[k] holds W[i-1-k]; win_q[nkm1_q] is therefore W[i-Nk].
  logic [31:0]         win_q [MAX_NK];
  logic [31:0]         win_d [MAX_NK];
  logic [5:0]          i_q, i_d;
  logic [5:0]          last_i_q, last_i_d;
  logic [IDX_W-1:0]    mod_q, mod_d;
  logic [IDX_W-1:0]    nkm1_q, nkm1_d;
  logic                nk8_q, nk8_d;
  logic                key_phase_q, key_phase_d;
  logic [7:0]          rcon_q, rcon_d;
  logic                rk_valid_q, rk_valid_d;
  logic [127:0]        rk_data_q, rk_data_d;
  logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [31:0]         key_w [MAX_NK];
  logic [3:0]          mode_nk;
  logic [5:0]          mode_last;
  logic                mode_ok;
  logic [IDX_W-1:0]    load_nkm1;
  logic [31:0]         w_prev, w_old, new_word;

  always_comb begin
    for (int j = 0; j < MAX_NK; j++) key_w[j] = key_in[32*(MAX_NK-1-j) +: 32];
  end

  // Mode decode: Nk and index of the last schedule word, 4*(Nr+1)-1.
  always_comb begin
    mode_nk   = 4'd4;
    mode_last = 6'd43;
    mode_ok   = 1'b1;
    case (mode)
      2'b00: begin
        mode_nk   = 4'd4;
        mode_last = 6'd43;
      end
      2'b01: begin
        mode_nk   = 4'd6;
        mode_last = 6'd51;
      end
      2'b10: begin
        mode_nk   = 4'd8;
        mode_last = 6'd59;
      end
      default: mode_ok = 1'b0;
    endcase
    if (mode_nk > 4'(MAX_NK)) mode_ok = 1'b0;
    load_nkm1 = IDX_W'(mode_nk - 4'd1);
  end

  // Round-word datapath. During the key phase the window is a rotating
  // buffer preloaded with the key, so W[i-Nk] already holds key word i.
  always_comb begin
    w_prev = win_q[0];
    w_old  = win_q[nkm1_q];
    if (key_phase_q) begin
      new_word = w_old;
    end else if (mod_q == '0) begin
      new_word = w_old ^ sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
    end else if (nk8_q && (mod_q == IDX_W'(4))) begin
      new_word = w_old ^ sub_word(w_prev);
    end else begin
      new_word = w_old ^ w_prev;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    i_d         = i_q;
    last_i_d    = last_i_q;
    mod_d       = mod_q;
    nkm1_d      = nkm1_q;
    nk8_d       = nk8_q;
    key_phase_d = key_phase_q;
    rcon_d      = rcon_q;
    rk_valid_d  = 1'b0;
    rk_data_d   = rk_data_q;
    rk_idx_d    = rk_idx_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            state_d     = ST_GEN;
            i_d         = '0;
            mod_d       = '0;
            key_phase_d = 1'b1;
            rcon_d      = 8'h01;
            nkm1_d      = load_nkm1;
            nk8_d       = (mode_nk == 4'd8);
            last_i_d    = mode_last;
            for (int k = 0; k < MAX_NK; k++) begin
              win_d[k] = '0;
              if (IDX_W'(k) <= load_nkm1) win_d[k] = key_w[load_nkm1 - IDX_W'(k)];
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_GEN: begin
        win_d[0] = new_word;
        for (int k = 1; k < MAX_NK; k++) win_d[k] = win_q[k-1];
        i_d = i_q + 6'd1;
        if (mod_q == nkm1_q) begin
          mod_d       = '0;
          key_phase_d = 1'b0;
        end else begin
          mod_d = mod_q + 1'b1;
        end
        if (!key_phase_q && (mod_q == '0)) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (i_q[1:0] == 2'b11) begin
          rk_valid_d = 1'b1;
          rk_data_d  = {win_q[2], win_q[1], win_q[0], new_word};
          rk_idx_d   = RK_IDX_W'(i_q >> 2);
        end
        if (i_q == last_i_q) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_q       <= '{default: '0};
      i_q         <= '0;
      last_i_q    <= '0;
      mod_q       <= '0;
      nkm1_q      <= '0;
      nk8_q       <= 1'b0;
      key_phase_q <= 1'b0;
      rcon_q      <= '0;
      rk_valid_q  <= 1'b0;
      rk_data_q   <= '0;
      rk_idx_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      i_q         <= i_d;
      last_i_q    <= last_i_d;
      mod_q       <= mod_d;
      nkm1_q      <= nkm1_d;
      nk8_q       <= nk8_d;
      key_phase_q <= key_phase_d;
      rcon_q      <= rcon_d;
      rk_valid_q  <= rk_valid_d;
      rk_data_q   <= rk_data_d;
      rk_idx_q    <= rk_idx_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/aes_key_sched_iter.md
Name: aes_key_sched_iter

Overview:
- Iterative, sequential AES key-schedule engine. Supports AES-128, AES-192 and AES-256, selected per run.
- Replaces chains of combinational per-round expansion stages with one shared round-word datapath. Produces one 32-bit schedule word per clock.
- Emits each 128-bit round key with a one-cycle valid strobe and its round index, so the cipher core can write its round-key store.

Parameters:
- MAX_NK, 8, largest key length in 32-bit words. Legal values are 4, 6 and 8; modes whose Nk exceeds MAX_NK are rejected.
- RK_IDX_W, 4, width of the round-index output. Must satisfy 2^RK_IDX_W > Nr_max.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request to expand; accepted only while ready=1.
- mode  in  2  2'b00 = AES-128 (Nk=4, Nr=10); 2'b01 = AES-192 (Nk=6, Nr=12); 2'b10 = AES-256 (Nk=8, Nr=14); 2'b11 is illegal.
- key_in  in  32*MAX_NK  cipher key, MSB-aligned. Word 0 is bits [32*MAX_NK-1 -: 32]. Unused low words are ignored.
- ready  out  1  idle, able to accept start.
- rk_valid  out  1  one-cycle strobe: rk_data and rk_idx are valid.
- rk_data  out  128  round key; word 4r is in bits [127:96].
- rk_idx  out  RK_IDX_W  round number r, from 0 to Nr.
- done  out  1  one-cycle pulse, coincident with the final rk_valid.
- err  out  1  one-cycle pulse: illegal mode at start, or Nk > MAX_NK.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE;
  - ready=1; rk_valid=0; done=0; err=0; rk_data=0; rk_idx=0;
  - word window, word counter and rcon register are cleared.
  - Reset mid-run aborts the run with no further rk_valid; the next run starts clean.
- States:
  - IDLE: ready=1. On start=1:
    - legal mode: latch key_in and Nk/Nr, set i=0, rcon=8'h01, go to GEN;
    - illegal mode: pulse err for one cycle and stay in IDLE.
  - GEN: ready=0. One word W[i] is produced per cycle for i = 0 .. 4(Nr+1)-1, i.e. 44, 52 or 60 cycles. Rule for W[i]:
    - i<Nk: W[i] = key word i.
    - i mod Nk == 0: W[i] = W[i-Nk] ^ SubWord(RotWord(W[i-1])) ^ {rcon,24'h0}. After this word, rcon <= xtime(rcon) (0x80 -> 0x1b).
    - Nk=8 and i mod 8 == 4: W[i] = W[i-8] ^ SubWord(W[i-1]).
    - otherwise: W[i] = W[i-8+...] as W[i-Nk] ^ W[i-1].
  - History is an MAX_NK-word shift window. No full-schedule RAM is kept.
  - When i mod 4 == 3, the registered outputs in the next cycle are: rk_valid=1, rk_data = {W[i-3], W[i-2], W[i-1], W[i]}, rk_idx = i>>2.
  - After the last word the state returns to IDLE. ready rises in the cycle after the done pulse.
- Timing:
  - start accepted at edge E.
  - rk_valid for round r is high in the cycle after edge E+4r+4.
  - Round keys are exactly 4 cycles apart; there are Nr+1 strobes in total.
- No backpressure: the consumer must capture on rk_valid.
- start while busy is ignored, with no err. key_in and mode may change freely after acceptance.
- SubWord uses four S-box lookups in one cycle. The S-box is combinational, internal to the block, and forward-only.
- rcon is consumed 10 times (AES-128), 8 times (AES-192) and 7 times (AES-256). The final value is never used beyond the 0x36 step.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk_idx 0 = key;
  - rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - exactly 11 strobes, 4 cycles apart; done with the last one.
- AES-192, key 000102030405060708090a0b0c0d0e0f1011121314151617:
  - rk_idx 12 = a4970a331a78dc09c418c271e3a41d5d;
  - 13 strobes; first strobe at E+5.
- AES-256, key 000102...1e1f:
  - rk_idx 14 = 24fc79ccbf0979e9371ac23c6d68de36;
  - rk_idx 1 = 101112131415161718191a1b1c1d1e1f;
  - 15 strobes.
- mode=2'b11 with start=1: err pulses one cycle, no rk_valid, ready stays 1. A following AES-128 run with key 000102...0f gives rk_idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- rst_n=0 after round 5 of an AES-256 run:
  - next cycle: ready=1, rk_valid=0;
  - immediate restart with the AES-128 FIPS key reproduces the expected keys;
  - start pulses held during GEN are ignored.
- Back-to-back runs: start held high continuously. A new run is accepted on the first ready=1 cycle, and rk_idx restarts at 0.
